// File: rtl/module_display_bcd_scan.sv
`timescale 1ns/1ps
// Display stage: sequential double-dabble binary-to-BCD converter feeding a
// multiplexed active-low 7-segment display. Option: DISPLAY_BLANK_LEADING_ZEROS_EN.
module module_display_bcd_scan #(
  parameter int WIDTH           = 4,
  parameter int DIGITS          = 2,
  parameter int DISPLAY_REFRESH = 27000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [WIDTH-1:0]  codigo_bin_i,
  output logic [DIGITS-1:0] anodo_o,
  output logic [6:0]        catodo_o,
  output logic              conv_busy_o
);
  localparam int BCD_W  = 4 * DIGITS;
  localparam int SR_W   = BCD_W + WIDTH;
  localparam int ITER_W = $clog2(WIDTH + 1);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SCAN_W = (DISPLAY_REFRESH > 1) ? $clog2(DISPLAY_REFRESH) : 1;
  localparam logic [SCAN_W-1:0] SCAN_RELOAD = SCAN_W'(DISPLAY_REFRESH - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  last_reg, last_next;
  logic [SR_W-1:0]   sr_reg, sr_next, sr_adj;
  logic [ITER_W-1:0] iter_reg, iter_next;
  logic [BCD_W-1:0]  bcd_reg, bcd_next;
  logic [SCAN_W-1:0] scan_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [DIGITS-1:0] anodo_reg;
  logic [6:0]        catodo_reg;
  logic [3:0]        digit_arr [DIGITS];
  logic [DIGITS-1:0] blank;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // The add-3 correction touches only the BCD nibbles; the binary tail passes through.
  assign sr_adj[WIDTH-1:0] = sr_reg[WIDTH-1:0];
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [3:0] nib;
    assign nib = sr_reg[WIDTH + 4*gi +: 4];
    assign sr_adj[WIDTH + 4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    assign digit_arr[gi] = bcd_reg[4*gi +: 4];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg <= IDLE;
      last_reg  <= '0;
      sr_reg    <= '0;
      iter_reg  <= '0;
      bcd_reg   <= '0;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      sr_reg    <= sr_next;
      iter_reg  <= iter_next;
      bcd_reg   <= bcd_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    sr_next    = sr_reg;
    iter_next  = iter_reg;
    bcd_next   = bcd_reg;
    case (state_reg)
      IDLE: begin
        if (codigo_bin_i != last_reg) begin
          last_next  = codigo_bin_i;
          sr_next    = {{BCD_W{1'b0}}, codigo_bin_i};
          iter_next  = ITER_W'(WIDTH);
          state_next = CONV;
        end
      end
      CONV: begin
        sr_next   = sr_adj << 1;
        iter_next = iter_reg - ITER_W'(1);
        if (iter_reg == ITER_W'(1)) state_next = DONE;
      end
      DONE: begin
        bcd_next   = sr_reg[SR_W-1 -: BCD_W];
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef DISPLAY_BLANK_LEADING_ZEROS_EN
  // A digit blanks only when it and every digit above it are zero.
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    blank      = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero & (digit_arr[i] == 4'd0);
      blank[i]   = upper_zero;
    end
  end
`else
  assign blank = '0;
`endif

  // Anode and cathode are registered together from the same index so they never skew.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      scan_reg   <= SCAN_RELOAD;
      idx_reg    <= '0;
      anodo_reg  <= '1;
      catodo_reg <= 7'h7F;
    end else begin
      if (scan_reg == '0) begin
        scan_reg <= SCAN_RELOAD;
        idx_reg  <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
      end else begin
        scan_reg <= scan_reg - SCAN_W'(1);
      end
      anodo_reg  <= ~(DIGITS'(1) << idx_reg);
      catodo_reg <= blank[idx_reg] ? 7'h7F : seg7(digit_arr[idx_reg]);
    end
  end

  assign anodo_o     = anodo_reg;
  assign catodo_o    = catodo_reg;
  assign conv_busy_o = (state_reg != IDLE);

endmodule
